load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the data-memory interface. Accepts one load/store request at a time from the pipeline MEM stage and validates alignment and range. It then sequences the word-wide data memory's level-sensitive read and rising-edge-of-write strobe, and returns sign- or zero-extended load data. Byte and halfword stores are handled by read-modify-write because the memory is word-only.

Parameters:
MEM_AW, 7, word-address width to data memory (byte address bits [MEM_AW+1:2]); 128 words
XLEN, 32, data and byte-address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (state IDLE)
req_funct3  in  3  RV32I funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
req_store  in  1  1 = store, 0 = load
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data (low bytes used for SB/SH)
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_rdata  out  XLEN  extended load data (0 for stores/errors)
resp_err  out  1  misaligned, out-of-range or illegal funct3
mem_read  out  1  memory read enable
mem_write  out  1  memory write strobe (memory writes on its rising edge)
mem_addr  out  MEM_AW  word address
mem_wdata  out  XLEN  word write data
mem_rdata  in  XLEN  combinational read data from memory

Behaviour:
- All state and all mem_* and resp_* outputs are registered. Reset (sync) -> IDLE; resp_valid, resp_err, mem_read, mem_write = 0; mem_addr, mem_wdata, resp_rdata = 0.
- req_ready = (state == IDLE). Accept on req_valid && req_ready; latch funct3, store, addr, wdata.
- Error check at accept: halfword with addr[0]; word with addr[1:0] != 0; addr[XLEN-1:MEM_AW+2] != 0; funct3 011/110/111, or 100/101 with req_store. On error go straight to RESP with resp_err=1 and resp_rdata=0; no mem_read or mem_write pulse.
- States: IDLE, RD, WR_SETUP, WR_PULSE, RESP.
- Load: IDLE -> RD. In RD, mem_read=1 and mem_addr is valid; mem_rdata is sampled at the end of RD. RD -> RESP. resp_valid rises 2 cycles after accept.
- SW: IDLE -> WR_SETUP -> WR_PULSE -> RESP.
  - WR_SETUP: mem_addr and mem_wdata driven, mem_write=0.
  - WR_PULSE: mem_write=1; addr and data unchanged.
  - mem_write=0 again in RESP.
  - Guarantees addr/data are stable one full cycle before the strobe edge.
- SB/SH: IDLE -> RD -> WR_SETUP -> WR_PULSE -> RESP. The word captured in RD is merged with the store lanes selected by addr[1:0]; all other bytes are preserved.
- Load extract by addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready. On resp_valid && resp_ready go to IDLE. No request is accepted in the same cycle, so max throughput is one request per (latency+1) cycles.
- mem_read and mem_write are never asserted together. mem_write is high for exactly one cycle per store.
- Reset mid-operation:
  - In RD or WR_SETUP: no memory write occurs.
  - In WR_PULSE: the write has already committed at the strobe edge; mem_write deasserts.
  - In RESP: the response is discarded.
  - In all cases the unit is in IDLE with req_ready=1 in the first cycle after reset deasserts.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - state encoding lsu_state_t
  - MEM_AW default
- One combinational sub-module, lsu_lane_align:
  - inputs: funct3, addr[1:0], old word, store data, read word
  - outputs: merged store word, extended load word
- The FSM and registers stay in load_store_unit.

Test Plan:
- Word N preloaded to N. LW addr 0x10 -> mem_read=1 for exactly one cycle with mem_addr=4; resp_valid 2 cycles after accept; resp_rdata=0x00000004, resp_err=0.
- SB addr 0x21, wdata 0x000000AB (word 8 = 0x00000008) -> RD, WR_SETUP, then a one-cycle mem_write with mem_wdata=0x0000AB08. Follow-up checks:
  - LW 0x20 returns 0x0000AB08
  - LB 0x21 returns 0xFFFFFFAB
  - LBU 0x21 returns 0x000000AB
- SH addr 0x03 and LW addr 0x202 -> resp_valid 1 cycle after accept with resp_err=1 and resp_rdata=0; mem_read and mem_write never asserted.
- SW addr 0x40, wdata 0xDEADBEEF, with reset asserted during WR_SETUP -> mem_write never rises; word 16 still reads 0x00000010; req_ready=1 in the first cycle after reset deasserts.
- LH addr 0x12 with resp_ready held low 5 cycles -> resp_valid, resp_rdata=0x00000000 and resp_err held stable; req_ready=0 throughout; IDLE one cycle after resp_ready.
- Back-to-back SW 0x8 (0x11223344) then LHU 0xA -> second request accepted only after RESP handshake; resp_rdata=0x00001122.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 width encodings used by loads and stores
//   - FSM state encoding
//   - default geometry of the data memory
//   - access_err(): decides at accept time whether a request is rejected
package lsu_pkg;

  localparam int MEM_AW_DEFAULT = 7;
  localparam int XLEN_DEFAULT   = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_RESP
  } lsu_state_t;

  // Misalignment, out-of-range and illegal width/direction combinations.
  function automatic logic access_err(input logic [2:0] funct3,
                                      input logic       store,
                                      input logic [1:0] addr_lo,
                                      input logic       out_of_range);
    logic err;
    err = out_of_range;
    case (funct3)
      F3_B:         ;
      F3_H:         if (addr_lo[0]) err = 1'b1;
      F3_W:         if (addr_lo != 2'b00) err = 1'b1;
      F3_BU, F3_HU: if (store) err = 1'b1;
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   funct3      access width / signedness
//   byte_off    byte offset within the word (addr[1:0])
//   old_word    word read back from memory, merged into for sub-word stores
//   store_data  store data from the pipeline (low bytes used for SB/SH)
//   read_word   word read from memory for loads
//   merged_word word to write back for a store
//   load_word   extracted and sign/zero-extended load result
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] read_word,
  output logic [XLEN-1:0] merged_word,
  output logic [XLEN-1:0] load_word
);

  logic [3:0]      lane_mask;
  logic [XLEN-1:0] store_rep;
  logic [XLEN-1:0] shifted;

  // Replicate the store data across the word so each selected lane can
  // simply take its own byte position.
  always_comb begin
    lane_mask = 4'b1111;
    store_rep = store_data;
    case (funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << byte_off;
        store_rep = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = lane_mask[gi] ? store_rep[gi*8 +: 8]
                                                    : old_word[gi*8 +: 8];
    end
  endgenerate

  assign shifted = read_word >> {byte_off, 3'b000};

  always_comb begin
    load_word = read_word;
    case (funct3)
      F3_B:    load_word = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_word = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   load_word = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_word = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_word = read_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-wide data memory.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_funct3/req_store       access width/sign and direction
//   req_addr/req_wdata         byte address and store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_err        extended load data, error flag
//   mem_read/mem_write         level read enable, rising-edge write strobe
//   mem_addr/mem_wdata         word address and write data
//   mem_rdata                  combinational memory read data
// Sub-word stores are read-modify-write since the memory has no byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT,
  parameter int XLEN   = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic              req_store,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_reg, state_next;
  logic [2:0]        funct3_reg;
  logic              store_reg;
  logic [1:0]        addr_lo_reg;
  logic [XLEN-1:0]   wdata_reg;

  logic              mem_read_next, mem_write_next;
  logic [MEM_AW-1:0] mem_addr_next;
  logic [XLEN-1:0]   mem_wdata_next;
  logic              resp_valid_next, resp_err_next;
  logic [XLEN-1:0]   resp_rdata_next;

  logic              accept;
  logic              req_err;
  logic [XLEN-1:0]   merged_word;
  logic [XLEN-1:0]   load_word;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = access_err(req_funct3, req_store, req_addr[1:0],
                                |req_addr[XLEN-1:MEM_AW+2]);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3      (funct3_reg),
    .byte_off    (addr_lo_reg),
    .old_word    (mem_rdata),
    .store_data  (wdata_reg),
    .read_word   (mem_rdata),
    .merged_word (merged_word),
    .load_word   (load_word)
  );

  always_comb begin
    state_next      = state_reg;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    resp_valid_next = 1'b0;
    resp_err_next   = resp_err;
    resp_rdata_next = resp_rdata;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next      = ST_RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
          end else begin
            mem_addr_next = req_addr[MEM_AW+1:2];
            // Full-word stores skip the read; everything else needs the old word.
            if (req_store && req_funct3 == F3_W) begin
              state_next     = ST_WR_SETUP;
              mem_wdata_next = req_wdata;
            end else begin
              state_next    = ST_RD;
              mem_read_next = 1'b1;
            end
          end
        end
      end
      ST_RD: begin
        if (store_reg) begin
          state_next     = ST_WR_SETUP;
          mem_wdata_next = merged_word;
        end else begin
          state_next      = ST_RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b0;
          resp_rdata_next = load_word;
        end
      end
      ST_WR_SETUP: begin
        // Address and data have been stable for a full cycle; raise the strobe.
        state_next     = ST_WR_PULSE;
        mem_write_next = 1'b1;
      end
      ST_WR_PULSE: begin
        state_next      = ST_RESP;
        resp_valid_next = 1'b1;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
      end
      ST_RESP: begin
        resp_valid_next = 1'b1;
        if (resp_ready) begin
          state_next      = ST_IDLE;
          resp_valid_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      funct3_reg  <= '0;
      store_reg   <= 1'b0;
      addr_lo_reg <= '0;
      wdata_reg   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      state_reg  <= state_next;
      mem_read   <= mem_read_next;
      mem_write  <= mem_write_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
      if (accept) begin
        funct3_reg  <= req_funct3;
        store_reg   <= req_store;
        addr_lo_reg <= req_addr[1:0];
        wdata_reg   <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory
// (word N holds N until written; writes land on the rising edge of mem_write).
module tb_load_store_unit;

  localparam int MEM_AW = 7;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic              req_store;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_AW(MEM_AW), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [XLEN-1:0] mem [0:127];
  bit              written [0:127];
  always @(posedge mem_write) begin
    mem[mem_addr]     <= mem_wdata;
    written[mem_addr] <= 1'b1;
  end
  assign mem_rdata = written[mem_addr] ? mem[mem_addr] : {25'd0, mem_addr};

  // Bus activity counters, sampled on the active edge before the DUT updates.
  int rd_count = 0;
  int wr_count = 0;
  int both_count = 0;
  logic [XLEN-1:0]   last_wdata = '0;
  logic [MEM_AW-1:0] last_waddr = '0;
  logic [MEM_AW-1:0] last_raddr = '0;
  always @(posedge clk) begin
    if (mem_read) begin
      rd_count   <= rd_count + 1;
      last_raddr <= mem_addr;
    end
    if (mem_write) begin
      wr_count   <= wr_count + 1;
      last_wdata <= mem_wdata;
      last_waddr <= mem_addr;
    end
    if (mem_read && mem_write) both_count <= both_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One complete request/response transaction, sampled on falling edges.
  task automatic do_req(input string tag, input logic [2:0] f3, input logic st,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat,
                        input int exp_rd, input int exp_wr);
    int rd0, wr0, lat;
    @(negedge clk);
    chk({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
    rd0 = rd_count;
    wr0 = wr_count;
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_store  = st;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      chk({tag, ":hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ":hold_rdata"}, resp_rdata, exp_data);
      chk({tag, ":hold_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      chk({tag, ":hold_ready"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk({tag, ":rdata"}, resp_rdata, exp_data);
    chk({tag, ":err"}, {31'd0, resp_err}, {31'd0, exp_err});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ":idle_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ":idle_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ":reads"}, rd_count - rd0, exp_rd);
    chk({tag, ":writes"}, wr_count - wr0, exp_wr);
    $display("TXN %s f3=%0d st=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
             tag, f3, st, addr, resp_rdata, resp_err, lat);
  endtask

  initial begin
    int wr0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_store  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst:ready", {31'd0, req_ready}, 32'd1);
    chk("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst:resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst:mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst:mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst:mem_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:resp_rdata", resp_rdata, 32'd0);

    // Plain word load
    do_req("lw_10", 3'b010, 1'b0, 32'h10, 32'h0, 0, 32'h00000004, 1'b0, 2, 1, 0);
    chk("lw_10:raddr", {25'd0, last_raddr}, 32'd4);

    // Byte store via read-modify-write, then read back three ways
    do_req("sb_21", 3'b000, 1'b1, 32'h21, 32'h000000AB, 0, 32'h0, 1'b0, 4, 1, 1);
    chk("sb_21:wdata", last_wdata, 32'h0000AB08);
    chk("sb_21:waddr", {25'd0, last_waddr}, 32'd8);
    do_req("lw_20", 3'b010, 1'b0, 32'h20, 32'h0, 0, 32'h0000AB08, 1'b0, 2, 1, 0);
    do_req("lb_21", 3'b000, 1'b0, 32'h21, 32'h0, 0, 32'hFFFFFFAB, 1'b0, 2, 1, 0);
    do_req("lbu_21", 3'b100, 1'b0, 32'h21, 32'h0, 0, 32'h000000AB, 1'b0, 2, 1, 0);

    // Rejected requests: no memory activity, response one cycle later
    do_req("sh_03", 3'b001, 1'b1, 32'h03, 32'h1234, 0, 32'h0, 1'b1, 1, 0, 0);
    do_req("lw_202", 3'b010, 1'b0, 32'h202, 32'h0, 0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sbu_04", 3'b100, 1'b1, 32'h04, 32'h0, 0, 32'h0, 1'b1, 1, 0, 0);
    do_req("f3_011", 3'b011, 1'b0, 32'h08, 32'h0, 0, 32'h0, 1'b1, 1, 0, 0);
    do_req("lb_1ff", 3'b000, 1'b0, 32'h1FF, 32'h0, 0, 32'h0, 1'b0, 2, 1, 0);

    // Reset during WR_SETUP of a word store: the write must not happen
    @(negedge clk);
    wr0 = wr_count;
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_store  = 1'b1;
    req_addr   = 32'h40;
    req_wdata  = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("sw_rst:ready", {31'd0, req_ready}, 32'd1);
    chk("sw_rst:mem_write", {31'd0, mem_write}, 32'd0);
    chk("sw_rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("sw_rst:writes", wr_count - wr0, 0);
    $display("TXN sw_rst addr=0x00000040 aborted by reset in WR_SETUP");
    do_req("lw_40", 3'b010, 1'b0, 32'h40, 32'h0, 0, 32'h00000010, 1'b0, 2, 1, 0);

    // Response back-pressure
    do_req("lh_12", 3'b001, 1'b0, 32'h12, 32'h0, 5, 32'h00000000, 1'b0, 2, 1, 0);

    // Back-to-back store then load of the same word
    do_req("sw_08", 3'b010, 1'b1, 32'h08, 32'h11223344, 2, 32'h0, 1'b0, 3, 0, 1);
    chk("sw_08:wdata", last_wdata, 32'h11223344);
    do_req("lhu_0a", 3'b101, 1'b0, 32'h0A, 32'h0, 0, 32'h00001122, 1'b0, 2, 1, 0);
    do_req("lh_08", 3'b001, 1'b0, 32'h08, 32'h0, 0, 32'h00003344, 1'b0, 2, 1, 0);

    // Halfword store into the upper lane, then signed halfword load
    do_req("sh_0a", 3'b001, 1'b1, 32'h0A, 32'h0000BEEF, 0, 32'h0, 1'b0, 4, 1, 1);
    chk("sh_0a:wdata", last_wdata, 32'hBEEF3344);
    do_req("lh_0a", 3'b001, 1'b0, 32'h0A, 32'h0, 0, 32'hFFFFBEEF, 1'b0, 2, 1, 0);

    chk("bus:read_and_write", both_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
